// File: rtl/calc2_port_sched.sv
// Per-port CALC2 request sequencer: allocates tags, issues the 2-cycle request, matches responses to completions.
// Latency: request on req_* the cycle after acceptance; completion one cycle after the response is sampled.
// Backpressure: op_ready drops while in CMD or when no tag is free; optional watchdog via CALC2_SCHED_TIMEOUT_EN.
module calc2_port_sched #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_data1,
    input  logic [31:0] op_data2,
    output logic [3:0]  req_cmd_in,
    output logic [31:0] req_data_in,
    output logic [1:0]  req_tag_in,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    input  logic [1:0]  out_tag,
    output logic        cpl_valid,
    output logic [1:0]  cpl_resp,
    output logic [31:0] cpl_data,
    output logic [1:0]  cpl_tag,
    output logic        cpl_timeout,
    output logic [2:0]  outstanding_cnt,
    output logic        err_spurious
);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("calc2_port_sched: illegal MAX_OUTSTANDING or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA2} state_t;

    state_t      state, state_nxt;
    logic        run;
    logic [3:0]  busy, busy_nxt;
    logic [3:0]  cmd_q;
    logic [31:0] data1_q, data2_q;
    logic [1:0]  tag_q;
    logic        any_free;
    logic [1:0]  free_tag;
    logic        accept;
    logic        resp_vld, resp_hit, resp_miss;
    logic [3:0]  free_mask, alloc_mask, tmo_mask;
    logic        emit_vld, emit_to;
    logic [1:0]  emit_resp, emit_tag;
    logic [31:0] emit_data;

    // Lowest-numbered free tag, restricted to the configured tag range.
    always_comb begin
        any_free = 1'b0;
        free_tag = 2'd0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free = 1'b1;
                free_tag = 2'(i);
            end
        end
    end

    always_comb begin
        outstanding_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            outstanding_cnt = outstanding_cnt + {2'b00, busy[i]};
        end
    end

    assign op_ready  = run && (state != S_CMD) && any_free &&
                       (outstanding_cnt < 3'(MAX_OUTSTANDING));
    assign accept    = op_valid && op_ready;
    assign resp_vld  = (out_resp != 2'd0);
    assign resp_hit  = resp_vld && busy[out_tag];
    assign resp_miss = resp_vld && !busy[out_tag];

    assign free_mask  = resp_hit ? (4'b0001 << out_tag) : 4'b0000;
    assign alloc_mask = accept ? (4'b0001 << free_tag) : 4'b0000;
    // Allocation looks at the pre-update vector, so a tag freed now is reusable next cycle.
    assign busy_nxt   = (busy & ~free_mask & ~tmo_mask) | alloc_mask;

`ifdef CALC2_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] AGE_LIM = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] age [4];
    logic [3:0]    expired;
    logic          to_any, to_take;
    logic [1:0]    to_tag;
    logic          hold_vld;
    logic [1:0]    hold_tag;
    logic          cpl_to_q;

    // A real response to the same tag in the same cycle beats its timeout.
    always_comb begin
        expired = 4'b0000;
        to_any  = 1'b0;
        to_tag  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            expired[i] = busy[i] && (age[i] == AGE_LIM) &&
                         !(resp_hit && (out_tag == 2'(i)));
            if (expired[i]) begin
                to_any = 1'b1;
                to_tag = 2'(i);
            end
        end
    end

    // A new timeout is taken only if the hold slot is empty or drains this cycle.
    assign to_take  = to_any && (!hold_vld || !resp_hit);
    assign tmo_mask = to_take ? (4'b0001 << to_tag) : 4'b0000;

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            hold_vld <= 1'b0;
            hold_tag <= 2'd0;
            for (int i = 0; i < 4; i++) age[i] <= '0;
        end else begin
            if (resp_hit) begin
                hold_vld <= hold_vld || to_take;
                hold_tag <= hold_vld ? hold_tag : to_tag;
            end else begin
                hold_vld <= hold_vld && to_take;
                hold_tag <= to_tag;
            end
            for (int i = 0; i < 4; i++) begin
                if (alloc_mask[i])
                    age[i] <= '0;
                else if (busy[i] && (age[i] != AGE_LIM))
                    age[i] <= age[i] + TW'(1);
            end
        end
    end

    always_comb begin
        emit_vld  = resp_hit;
        emit_to   = 1'b0;
        emit_resp = out_resp;
        emit_data = out_data;
        emit_tag  = out_tag;
        if (!resp_hit && (hold_vld || to_take)) begin
            emit_vld  = 1'b1;
            emit_to   = 1'b1;
            emit_resp = 2'd0;
            emit_data = 32'd0;
            emit_tag  = hold_vld ? hold_tag : to_tag;
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) cpl_to_q <= 1'b0;
        else        cpl_to_q <= emit_to;
    end
    assign cpl_timeout = cpl_to_q;
`else
    assign tmo_mask    = 4'b0000;
    assign emit_vld    = resp_hit;
    assign emit_to     = 1'b0;
    assign emit_resp   = out_resp;
    assign emit_data   = out_data;
    assign emit_tag    = out_tag;
    assign cpl_timeout = emit_to;
`endif

    always_ff @(posedge c_clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = accept ? S_CMD : S_IDLE;
            S_CMD:   state_nxt = S_DATA2;
            S_DATA2: state_nxt = accept ? S_CMD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        req_tag_in  = 2'd0;
        case (state)
            S_CMD: begin
                req_cmd_in  = cmd_q;
                req_data_in = data1_q;
                req_tag_in  = tag_q;
            end
            S_DATA2: req_data_in = data2_q;
            default: ;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            run          <= 1'b0;
            busy         <= 4'b0000;
            cmd_q        <= 4'd0;
            data1_q      <= 32'd0;
            data2_q      <= 32'd0;
            tag_q        <= 2'd0;
            cpl_valid    <= 1'b0;
            cpl_resp     <= 2'd0;
            cpl_data     <= 32'd0;
            cpl_tag      <= 2'd0;
            err_spurious <= 1'b0;
        end else begin
            run       <= 1'b1;
            busy      <= busy_nxt;
            cpl_valid <= emit_vld;
            if (accept) begin
                cmd_q   <= op_cmd;
                data1_q <= op_data1;
                data2_q <= op_data2;
                tag_q   <= free_tag;
            end
            if (emit_vld) begin
                cpl_resp <= emit_resp;
                cpl_data <= emit_data;
                cpl_tag  <= emit_tag;
            end
            if (resp_miss) err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_calc2_port_sched.sv
// Bench for calc2_port_sched: directed vector table, corner-case sequences, and a randomized run against a queue model.
module tb_calc2_port_sched;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  op_cmd = 4'd0;
    logic [31:0] op_data1 = 32'd0, op_data2 = 32'd0;
    logic [1:0]  out_resp = 2'd0, out_tag = 2'd0;
    logic [31:0] out_data = 32'd0;
    logic        op_ready, cpl_valid, cpl_timeout, err_spurious;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in, cpl_data;
    logic [1:0]  req_tag_in, cpl_resp, cpl_tag;
    logic [2:0]  outstanding_cnt;

    calc2_port_sched dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
        .op_data1(op_data1), .op_data2(op_data2),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .cpl_valid(cpl_valid), .cpl_resp(cpl_resp), .cpl_data(cpl_data), .cpl_tag(cpl_tag),
        .cpl_timeout(cpl_timeout), .outstanding_cnt(outstanding_cnt), .err_spurious(err_spurious)
    );

    always #5 c_clk = ~c_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        op_valid = 1'b0;
        out_resp = 2'd0;
        reset    = 1'b0;
        repeat (2) @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
    endtask

    function automatic logic [31:0] calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  resp;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] res;
        int          ready_at;
    } inflight_t;

    vec_t      vecs [6];
    inflight_t fl [$];
    logic [1:0] seen_tags [$];

    initial begin
        vecs[0] = '{4'd1, 32'h5,  32'h3, 2'd1, 32'h8};
        vecs[1] = '{4'd2, 32'ha,  32'h4, 2'd1, 32'h6};
        vecs[2] = '{4'd5, 32'h1,  32'h4, 2'd1, 32'h10};
        vecs[3] = '{4'd6, 32'h80, 32'h3, 2'd1, 32'h10};
        vecs[4] = '{4'd2, 32'h0,  32'h1, 2'd2, 32'hffffffff};
        vecs[5] = '{4'd9, 32'h7,  32'h7, 2'd3, 32'h0};

        // Reset values while reset is held low.
        repeat (2) @(negedge c_clk);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_req_cmd", req_cmd_in, 0);
        chk("rst_req_data", req_data_in, 0);
        chk("rst_cpl_valid", cpl_valid, 0);
        chk("rst_cnt", outstanding_cnt, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_timeout", cpl_timeout, 0);
        reset = 1'b1;
        @(negedge c_clk);

        // Directed single operations from an idle scheduler.
        for (int i = 0; i < 6; i++) begin
            chk("vec_ready", op_ready, 1);
            op_valid = 1'b1; op_cmd = vecs[i].cmd; op_data1 = vecs[i].d1; op_data2 = vecs[i].d2;
            @(negedge c_clk);
            op_valid = 1'b0;
            chk("vec_cmd", req_cmd_in, vecs[i].cmd);
            chk("vec_data1", req_data_in, vecs[i].d1);
            chk("vec_tag", req_tag_in, 0);
            chk("vec_ready_cmd", op_ready, 0);
            chk("vec_cnt_busy", outstanding_cnt, 1);
            @(negedge c_clk);
            chk("vec_cmd2", req_cmd_in, 0);
            chk("vec_data2", req_data_in, vecs[i].d2);
            out_resp = vecs[i].resp; out_tag = 2'd0; out_data = vecs[i].res;
            @(negedge c_clk);
            out_resp = 2'd0;
            chk("vec_cpl_valid", cpl_valid, 1);
            chk("vec_cpl_resp", cpl_resp, vecs[i].resp);
            chk("vec_cpl_data", cpl_data, vecs[i].res);
            chk("vec_cpl_tag", cpl_tag, 0);
            chk("vec_cpl_to", cpl_timeout, 0);
            chk("vec_cnt_free", outstanding_cnt, 0);
            @(negedge c_clk);
            chk("vec_cpl_pulse", cpl_valid, 0);
            chk("vec_cpl_hold", cpl_data, vecs[i].res);
        end

        // Fill all tags with op_valid held, then free tag 2 and see it reused.
        do_reset();
        op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'h11; op_data2 = 32'h22;
        for (int i = 0; i < 12; i++) begin
            @(negedge c_clk);
            if (req_cmd_in != 4'd0) seen_tags.push_back(req_tag_in);
        end
        chk("fill_count", seen_tags.size(), 4);
        for (int i = 0; i < 4 && i < seen_tags.size(); i++) chk("fill_tag", seen_tags[i], i);
        chk("fill_cnt", outstanding_cnt, 4);
        chk("fill_ready", op_ready, 0);
        out_resp = 2'd1; out_tag = 2'd2; out_data = 32'h33;
        @(negedge c_clk);
        out_resp = 2'd0;
        chk("fill_cpl_valid", cpl_valid, 1);
        chk("fill_cpl_tag", cpl_tag, 2);
        chk("fill_cnt_after", outstanding_cnt, 3);
        chk("fill_ready_after", op_ready, 1);
        @(negedge c_clk);
        op_valid = 1'b0;
        chk("reuse_cmd", req_cmd_in, 1);
        chk("reuse_tag", req_tag_in, 2);
        chk("reuse_cnt", outstanding_cnt, 4);

        // Spurious response for a tag that is not busy.
        do_reset();
        op_valid = 1'b1; op_cmd = 4'd2; op_data1 = 32'h9; op_data2 = 32'h1;
        @(negedge c_clk);
        op_valid = 1'b0;
        repeat (2) @(negedge c_clk);
        out_resp = 2'd1; out_tag = 2'd3; out_data = 32'h55;
        @(negedge c_clk);
        out_resp = 2'd0;
        chk("spur_err", err_spurious, 1);
        chk("spur_cpl", cpl_valid, 0);
        chk("spur_cnt", outstanding_cnt, 1);
        @(negedge c_clk);
        chk("spur_sticky", err_spurious, 1);

        // Reset landing in the DATA2 cycle.
        do_reset();
        op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'hab; op_data2 = 32'hcd;
        @(negedge c_clk);
        op_valid = 1'b0;
        @(negedge c_clk);
        chk("d2rst_pre_data", req_data_in, 32'hcd);
        reset = 1'b0;
        @(negedge c_clk);
        chk("d2rst_cmd", req_cmd_in, 0);
        chk("d2rst_data", req_data_in, 0);
        chk("d2rst_tag", req_tag_in, 0);
        chk("d2rst_cnt", outstanding_cnt, 0);
        chk("d2rst_ready", op_ready, 0);
        chk("d2rst_err", err_spurious, 0);
        reset = 1'b1;
        @(negedge c_clk);
        chk("d2rst_ready_rel", op_ready, 1);

        // Randomized traffic against a queue/array model of tag ownership.
        do_reset();
        begin
            bit          mbusy [4];
            bit          cmd_ph, d2_ph, prev_nz, exp_ready, resp_now, acc;
            logic [3:0]  p_cmd;
            logic [31:0] p_d1, p_d2, d2_prev;
            logic [1:0]  p_tag, r_tag, new_tag;
            logic [31:0] r_data;
            bit          e_vld;
            logic [1:0]  e_tag;
            logic [31:0] e_data;
            logic [3:0]  cmds [4];
            int          nbusy, nfree;
            int          elig [$];
            cmds[0] = 4'd1; cmds[1] = 4'd2; cmds[2] = 4'd5; cmds[3] = 4'd6;
            for (int t = 0; t < 4; t++) mbusy[t] = 1'b0;
            cmd_ph = 0; d2_ph = 0; prev_nz = 0; e_vld = 0;
            p_cmd = 0; p_d1 = 0; p_d2 = 0; d2_prev = 0; p_tag = 0; e_tag = 0; e_data = 0;
            fl.delete();
            for (int k = 0; k < 800; k++) begin
                nbusy = 0;
                for (int t = 0; t < 4; t++) nbusy += mbusy[t];
                nfree = 4 - nbusy;
                exp_ready = !cmd_ph && (nfree > 0);
                chk("rnd_ready", op_ready, exp_ready);
                chk("rnd_cnt", outstanding_cnt, nbusy);
                if (cmd_ph) begin
                    chk("rnd_cmd", req_cmd_in, p_cmd);
                    chk("rnd_data1", req_data_in, p_d1);
                    chk("rnd_tag", req_tag_in, p_tag);
                end else begin
                    chk("rnd_cmd_idle", req_cmd_in, 0);
                    chk("rnd_data_idle", req_data_in, d2_ph ? d2_prev : 32'd0);
                end
                chk("rnd_alternate", prev_nz && (req_cmd_in != 4'd0), 0);
                prev_nz = (req_cmd_in != 4'd0);
                chk("rnd_cpl_valid", cpl_valid, e_vld);
                if (e_vld) begin
                    chk("rnd_cpl_tag", cpl_tag, e_tag);
                    chk("rnd_cpl_data", cpl_data, e_data);
                    chk("rnd_cpl_resp", cpl_resp, 1);
                end

                op_valid = ($urandom_range(0, 3) != 0);
                op_cmd   = cmds[$urandom_range(0, 3)];
                op_data1 = $urandom;
                op_data2 = $urandom;
                resp_now = 0;
                r_tag = 0; r_data = 0;
                elig.delete();
                for (int j = 0; j < fl.size(); j++) if (fl[j].ready_at <= k) elig.push_back(j);
                if (elig.size() > 0 && $urandom_range(0, 2) == 0) begin
                    int j;
                    j = elig[$urandom_range(0, elig.size() - 1)];
                    r_tag = fl[j].tag; r_data = fl[j].res;
                    fl.delete(j);
                    resp_now = 1;
                end
                out_resp = resp_now ? 2'd1 : 2'd0;
                out_tag  = r_tag;
                out_data = r_data;

                acc = op_valid && exp_ready;
                new_tag = 0;
                if (acc) begin
                    for (int t = 3; t >= 0; t--) if (!mbusy[t]) new_tag = 2'(t);
                end
                if (resp_now) mbusy[r_tag] = 1'b0;
                if (acc) begin
                    mbusy[new_tag] = 1'b1;
                    fl.push_back('{new_tag, calc(op_cmd, op_data1, op_data2), k + 2});
                end
                e_vld = resp_now;
                if (resp_now) begin e_tag = r_tag; e_data = r_data; end
                d2_ph   = cmd_ph;
                d2_prev = p_d2;
                cmd_ph  = acc;
                if (acc) begin
                    p_cmd = op_cmd; p_d1 = op_data1; p_d2 = op_data2; p_tag = new_tag;
                end
                @(negedge c_clk);
            end
            op_valid = 1'b0;
            out_resp = 2'd0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
